// File: rtl/clk_meas.sv
// clk_meas: period and duty-cycle meter for a slow signal that is
// asynchronous to clock_in. It counts clock_in cycles between consecutive
// rising edges and presents each completed period on a valid/ready port.
// Optional feature: define CLK_MEAS_DUTY_EN to also measure the high time.
// Without it, high_time is tied to 0.
module clk_meas #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] MAX_PERIOD = 32'd100000000
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             overrun,
  output logic             timeout
);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  logic             s1, s2, s3;
  logic             rise;
  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] period_reg;
  logic             load;
  logic             tmo_hit;
  logic             accept;
  logic             valid_reg, valid_next;
  logic             overrun_reg, overrun_next;
  logic             timeout_reg;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // State register and cycle counter.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state and counter. Also decodes the result-load and timeout events.
  // A rise always wins over the timeout limit in the same cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    tmo_hit    = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rise) begin
          cnt_next   = WIDTH'(1);
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          load     = 1'b1;
          cnt_next = WIDTH'(1);
        end else if (cnt_reg == MAX_PERIOD) begin
          tmo_hit    = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + WIDTH'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Period field. It is loaded with the running count on each measured rise.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      period_reg <= '0;
    end else if (load) begin
      period_reg <= cnt_reg;
    end
  end

  // One-cycle timeout pulse when the count reaches the limit without a rise.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= tmo_hit;
    end
  end

  assign accept = valid_reg & meas_ready;

  // Handshake bookkeeping. A load that coincides with an accept is not an
  // overrun, and it also clears any overrun that was already flagged.
  always_comb begin
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    if (load) begin
      valid_next = 1'b1;
      if (valid_reg & ~accept) begin
        overrun_next = 1'b1;
      end else if (accept) begin
        overrun_next = 1'b0;
      end
    end else if (accept) begin
      valid_next   = 1'b0;
      overrun_next = 1'b0;
    end
  end

  // Valid and sticky overrun registers.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

`ifdef CLK_MEAS_DUTY_EN
  logic             fall;
  logic [WIDTH-1:0] hi_cap_reg;
  logic [WIDTH-1:0] high_reg;

  assign fall = ~s2 & s3;

  // Capture the count at the falling edge. A timeout clears the capture so
  // that a stale high time is not carried into the next measurement.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      hi_cap_reg <= '0;
    end else if (tmo_hit) begin
      hi_cap_reg <= '0;
    end else if ((state_reg == MEASURE) && fall) begin
      hi_cap_reg <= cnt_reg;
    end
  end

  // High-time field. It is loaded together with the period.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      high_reg <= '0;
    end else if (load) begin
      high_reg <= hi_cap_reg;
    end
  end

  assign high_time = high_reg;
`else
  assign high_time = '0;
`endif

  assign meas_valid = valid_reg;
  assign period     = period_reg;
  assign overrun    = overrun_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_clk_meas.sv
// tb_clk_meas: randomized self-checking bench for clk_meas.
// The reference model works on timestamps of sampled input edges. It runs
// alongside directed scenarios that carry hand-computed literal expectations.
`timescale 1ns/1ps
module tb_clk_meas;

  localparam int W    = 32;
  localparam int MAXP = 200;
`ifdef CLK_MEAS_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic          clock_in = 1'b0;
  logic          reset = 1'b1;
  logic          sig_in = 1'b0;
  logic          meas_ready = 1'b0;
  logic          meas_valid;
  logic [W-1:0]  period;
  logic [W-1:0]  high_time;
  logic          overrun;
  logic          timeout;

  int total = 0;
  int bad = 0;

  clk_meas #(.WIDTH(W), .MAX_PERIOD(32'd200)) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .sig_in     (sig_in),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .period     (period),
    .high_time  (high_time),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. It keeps time-stamps of edges in the sampled input
  // stream. An edge seen at sample k acts at sample k+2.
  bit h1, h2, h3;
  bit m_meas, m_valid, m_over, m_tmo;
  int now, m_rise_t, m_hi, m_period, m_high;

  always @(posedge clock_in or posedge reset) begin : model
    bit r, f, acc, ld;
    int np, nh;
    if (reset) begin
      h1 = 0; h2 = 0; h3 = 0;
      m_meas = 0; m_valid = 0; m_over = 0; m_tmo = 0;
      now = 0; m_rise_t = 0; m_hi = 0; m_period = 0; m_high = 0;
    end else begin
      now++;
      r   = h2 && !h3;
      f   = !h2 && h3;
      acc = m_valid && meas_ready;
      ld  = 0; np = 0; nh = 0;
      m_tmo = 0;
      if (r) begin
        if (m_meas) begin
          ld = 1;
          np = now - m_rise_t;
          nh = DUTY ? m_hi : 0;
        end
        m_meas   = 1;
        m_rise_t = now;
      end else if (m_meas) begin
        if (now - m_rise_t == MAXP) begin
          m_tmo = 1; m_meas = 0; m_hi = 0;
        end else if (f) begin
          m_hi = now - m_rise_t;
        end
      end
      if (ld) begin
        if (m_valid && !acc) m_over = 1;
        else if (acc) m_over = 0;
        m_valid  = 1;
        m_period = np;
        m_high   = nh;
      end else if (acc) begin
        m_valid = 0;
        m_over  = 0;
      end
      h3 = h2; h2 = h1; h1 = sig_in;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock_in) begin
    check("valid", meas_valid, m_valid);
    check("overrun", overrun, m_over);
    check("timeout", timeout, m_tmo);
    check("period", period, m_period);
    check("high_time", high_time, m_high);
  end

  // Log each accepted result and keep the last one for the directed checks.
  int n_acc = 0;
  int last_p = 0;
  int last_h = 0;
  always @(negedge clock_in) begin
    if (!reset && meas_valid && meas_ready) begin
      n_acc++;
      last_p = period;
      last_h = high_time;
      $display("accept t=%0t period=%0d high_time=%0d overrun=%0b", $time, period, high_time, overrun);
    end
  end

  bit rand_ready = 0;

  // Inputs change 2 ns after the falling edge, well away from both edges.
  task automatic step();
    @(negedge clock_in);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drive(input int hi, input int lo);
    for (int i = 0; i < hi + lo; i++) begin
      sig_in = (i < hi);
      if (rand_ready) meas_ready = ($urandom_range(0, 3) != 0);
      step();
    end
  endtask

  int tmo_at, tmo_cnt, nv;

  initial begin
    // Reset state.
    step();
    step();
    check("rst_valid", meas_valid, 0);
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;

    // Square wave 100 cycles, 30 high, consumer always ready.
    meas_ready = 1'b1;
    n_acc = 0;
    drive(30, 70);
    drive(30, 70);
    drive(30, 70);
    check("sq_count", n_acc, 2);
    check("sq_period", last_p, 100);
    check("sq_high", last_h, DUTY ? 30 : 0);

    // Overrun: two unaccepted results, then one accept.
    do_reset();
    meas_ready = 1'b0;
    drive(25, 25);
    drive(25, 25);
    drive(25, 24);
    check("ovr_valid", meas_valid, 1);
    check("ovr_flag", overrun, 1);
    check("ovr_period", period, 50);
    check("ovr_high", high_time, DUTY ? 25 : 0);
    meas_ready = 1'b1;
    step();
    meas_ready = 1'b0;
    check("ovr_acc_valid", meas_valid, 0);
    check("ovr_acc_flag", overrun, 0);

    // Accept coinciding with a new result load, with overrun already set.
    drive(30, 30);
    drive(35, 35);
    check("coin_pre_flag", overrun, 1);
    sig_in = 1'b1;
    step();
    step();
    meas_ready = 1'b1;
    step();
    meas_ready = 1'b0;
    check("coin_valid", meas_valid, 1);
    check("coin_flag", overrun, 0);
    check("coin_period", period, 70);
    check("coin_high", high_time, DUTY ? 35 : 0);

    // Mid-operation reset while a result is pending.
    drive(20, 20);
    @(posedge clock_in);
    #2;
    reset = 1'b1;
    #1;
    check("mid_valid", meas_valid, 0);
    check("mid_period", period, 0);
    check("mid_high", high_time, 0);
    check("mid_overrun", overrun, 0);
    check("mid_timeout", timeout, 0);
    step();
    reset = 1'b0;
    sig_in = 1'b0;
    drive(40, 40);
    drive(40, 40);
    check("restart_valid", meas_valid, 1);
    check("restart_period", period, 80);
    check("restart_overrun", overrun, 0);

    // Timeout: one rise, then the signal stays low.
    do_reset();
    sig_in = 1'b0;
    meas_ready = 1'b1;
    step();
    n_acc = 0;
    tmo_at = 0;
    tmo_cnt = 0;
    nv = 0;
    for (int j = 1; j <= 260; j++) begin
      sig_in = (j <= 10);
      step();
      if (timeout) begin
        tmo_cnt++;
        if (tmo_at == 0) tmo_at = j;
      end
      if (meas_valid) nv++;
    end
    check("tmo_pulses", tmo_cnt, 1);
    check("tmo_when", tmo_at, 203);
    check("tmo_no_valid", nv, 0);
    drive(30, 30);
    drive(30, 30);
    check("tmo_after_count", n_acc, 1);
    check("tmo_after_period", last_p, 60);

    // Input held high through reset release.
    sig_in = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_acc = 0;
    drive(40, 40);
    check("hi_rst_no_result", n_acc, 0);
    drive(40, 40);
    check("hi_rst_count", n_acc, 1);
    check("hi_rst_period", last_p, 80);
    check("hi_rst_high", last_h, DUTY ? 40 : 0);

    // Randomized phase: random phases and random ready, with occasional
    // long lows that trigger timeouts and occasional resets.
    rand_ready = 1;
    for (int k = 0; k < 250; k++) begin
      int hi, lo;
      hi = $urandom_range(2, 90);
      lo = ($urandom_range(0, 9) == 0) ? $urandom_range(150, 260) : $urandom_range(2, 90);
      drive(hi, lo);
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end
    end
    rand_ready = 0;
    meas_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
